// File: rtl/clock_switch_controller.sv
// Clock-source switch sequencer: owns the glitch-free mux select, waits for the
// mux synchronizers to settle, reports completion, then holds off the next switch.
module clock_switch_controller #(
  parameter int   SETTLE_CYCLES = 16,
  parameter int   DWELL_CYCLES  = 32,
  parameter logic RESET_SELECT  = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_request_valid,
  input  logic i_request_select,
  output logic o_request_ready,
  output logic o_select,
  output logic o_active_select,
  output logic o_busy,
  output logic o_done
);
  // state  | meaning
  // IDLE   | select stable and settled, accepting requests
  // SETTLE | select toggled, waiting out the mux synchronizers
  // DWELL  | switch reported, holding off the next request
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DWELL  = 2'd2;

  localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST  = (DWELL_CYCLES > 0) ? CW'(DWELL_CYCLES - 1) : '0;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_select;
  logic          r_active;
  logic          r_busy;
  logic          r_done;

  logic [1:0]    w_state_next;
  logic          w_accept;
  logic          w_noop;
  logic          w_toggle;
  logic          w_settle_end;
  logic          w_dwell_end;

  assign w_accept     = i_request_valid && r_ready;
  assign w_noop       = w_accept && (r_state == S_IDLE) && (i_request_select == r_select);
  assign w_toggle     = w_accept && (r_state == S_IDLE) && (i_request_select != r_select);
  assign w_settle_end = (r_state == S_SETTLE) && (r_cnt == SETTLE_LAST);
  assign w_dwell_end  = (r_state == S_DWELL) && (r_cnt == DWELL_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_toggle) w_state_next = S_SETTLE;
      S_SETTLE: if (w_settle_end) w_state_next = (DWELL_CYCLES == 0) ? S_IDLE : S_DWELL;
      S_DWELL:  if (w_dwell_end) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // ready/busy are registered views of the next state so they flip together
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_select <= RESET_SELECT;
      r_active <= RESET_SELECT;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next == S_IDLE);
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_noop || w_settle_end;
      if (w_toggle) r_select <= i_request_select;
      if (w_settle_end) r_active <= r_select;
      if (w_toggle || w_settle_end || w_dwell_end || (r_state == S_IDLE))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_request_ready = r_ready;
  assign o_select        = r_select;
  assign o_active_select = r_active;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: tb/tb_clock_switch_controller.sv
// Bench for clock_switch_controller: default 16/32 instance plus a 4/0 zero-dwell
// instance, checked every cycle against a timestamp-based model and literal points.
module tb_clock_switch_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] v_in = 2'b00;
  logic [1:0] s_in = 2'b00;
  logic [1:0] d_ready, d_sel, d_act, d_busy, d_done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int s_cyc [2] = '{16, 4};
  int d_cyc [2] = '{32, 0};
  logic [1:0] m_sel   = 2'b00;
  logic [1:0] m_act   = 2'b00;
  logic [1:0] m_ready = 2'b00;
  logic [1:0] m_busy  = 2'b00;
  logic [1:0] m_done  = 2'b00;
  int t_acc [2] = '{-1, -1};
  int ecyc = 0;

  always #5 clk = ~clk;

  clock_switch_controller u_dut_a (
    .i_clock(clk), .i_reset(rst),
    .i_request_valid(v_in[0]), .i_request_select(s_in[0]),
    .o_request_ready(d_ready[0]), .o_select(d_sel[0]),
    .o_active_select(d_act[0]), .o_busy(d_busy[0]), .o_done(d_done[0])
  );

  clock_switch_controller #(.SETTLE_CYCLES(4), .DWELL_CYCLES(0), .RESET_SELECT(1'b0)) u_dut_b (
    .i_clock(clk), .i_reset(rst),
    .i_request_valid(v_in[1]), .i_request_select(s_in[1]),
    .o_request_ready(d_ready[1]), .o_select(d_sel[1]),
    .o_active_select(d_act[1]), .o_busy(d_busy[1]), .o_done(d_done[1])
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a switch accepted at cycle t completes at t+S and frees the port at t+S+D
  always @(posedge clk or posedge rst) begin
    if (rst) ecyc = 0;
    else ecyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_sel[i] = 1'b0; m_act[i] = 1'b0; m_ready[i] = 1'b0;
        m_busy[i] = 1'b0; m_done[i] = 1'b0; t_acc[i] = -1;
      end else begin
        m_done[i] = 1'b0;
        if (v_in[i] && m_ready[i]) begin
          if (s_in[i] == m_sel[i]) m_done[i] = 1'b1;
          else begin
            m_sel[i] = s_in[i];
            t_acc[i] = ecyc;
          end
        end
        if (t_acc[i] >= 0) begin
          if (ecyc == t_acc[i] + s_cyc[i]) begin
            m_done[i] = 1'b1;
            m_act[i]  = m_sel[i];
          end
          if (ecyc >= t_acc[i] + s_cyc[i] + d_cyc[i]) t_acc[i] = -1;
        end
        m_busy[i]  = (t_acc[i] >= 0);
        m_ready[i] = ~m_busy[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_select[%0d]", i), d_sel[i], m_sel[i]);
        chk($sformatf("model_active[%0d]", i), d_act[i], m_act[i]);
        chk($sformatf("model_ready[%0d]", i), d_ready[i], m_ready[i]);
        chk($sformatf("model_busy[%0d]", i), d_busy[i], m_busy[i]);
        chk($sformatf("model_done[%0d]", i), d_done[i], m_done[i]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    // reset values
    step(2);
    chk_en = 1'b1;
    chk("rst_select", d_sel[0], 1'b0);
    chk("rst_active", d_act[0], 1'b0);
    chk("rst_ready", d_ready[0], 1'b0);
    chk("rst_busy", d_busy[0], 1'b0);
    chk("rst_done", d_done[0], 1'b0);
    rst = 1'b0;
    #1 chk("ready_before_first_edge", d_ready[0], 1'b0);
    step(1);
    chk("ready_after_release_a", d_ready[0], 1'b1);
    chk("ready_after_release_b", d_ready[1], 1'b1);

    // single toggle, with a stalled request from N+5
    v_in[0] = 1'b1; s_in[0] = 1'b1;
    step(1);
    v_in[0] = 1'b0;
    chk("tog_select_N", d_sel[0], 1'b1);
    chk("tog_busy_N", d_busy[0], 1'b1);
    chk("tog_ready_N", d_ready[0], 1'b0);
    step(5);
    v_in[0] = 1'b1; s_in[0] = 1'b0;
    step(10);
    chk("tog_done_N15", d_done[0], 1'b0);
    chk("tog_active_N15", d_act[0], 1'b0);
    step(1);
    chk("tog_done_N16", d_done[0], 1'b1);
    chk("tog_active_N16", d_act[0], 1'b1);
    chk("tog_select_N16", d_sel[0], 1'b1);
    step(1);
    chk("tog_done_N17", d_done[0], 1'b0);
    step(30);
    chk("tog_ready_N47", d_ready[0], 1'b0);
    chk("tog_busy_N47", d_busy[0], 1'b1);
    step(1);
    chk("tog_ready_N48", d_ready[0], 1'b1);
    chk("tog_busy_N48", d_busy[0], 1'b0);
    chk("stall_select_N48", d_sel[0], 1'b1);
    step(1);
    v_in[0] = 1'b0;
    chk("stall_select_N49", d_sel[0], 1'b0);
    chk("stall_ready_N49", d_ready[0], 1'b0);
    step(15);
    chk("stall_done_N64", d_done[0], 1'b0);
    step(1);
    chk("stall_done_N65", d_done[0], 1'b1);
    chk("stall_active_N65", d_act[0], 1'b0);
    step(31);
    chk("stall_ready_N96", d_ready[0], 1'b0);
    step(1);
    chk("stall_ready_N97", d_ready[0], 1'b1);

    // no-op request
    v_in[0] = 1'b1; s_in[0] = 1'b0;
    step(1);
    v_in[0] = 1'b0;
    chk("noop_done", d_done[0], 1'b1);
    chk("noop_select", d_sel[0], 1'b0);
    chk("noop_busy", d_busy[0], 1'b0);
    chk("noop_ready", d_ready[0], 1'b1);
    step(1);
    chk("noop_done_after", d_done[0], 1'b0);
    chk("noop_ready_after", d_ready[0], 1'b1);

    // zero dwell, back-to-back
    v_in[1] = 1'b1; s_in[1] = 1'b1;
    step(1);
    v_in[1] = 1'b0;
    chk("zd_select_N", d_sel[1], 1'b1);
    chk("zd_ready_N", d_ready[1], 1'b0);
    step(3);
    chk("zd_done_N3", d_done[1], 1'b0);
    chk("zd_ready_N3", d_ready[1], 1'b0);
    step(1);
    chk("zd_done_N4", d_done[1], 1'b1);
    chk("zd_ready_N4", d_ready[1], 1'b1);
    chk("zd_active_N4", d_act[1], 1'b1);
    chk("zd_busy_N4", d_busy[1], 1'b0);
    v_in[1] = 1'b1; s_in[1] = 1'b0;
    step(1);
    v_in[1] = 1'b0;
    chk("zd_b2b_select_N5", d_sel[1], 1'b0);
    chk("zd_b2b_ready_N5", d_ready[1], 1'b0);
    chk("zd_b2b_busy_N5", d_busy[1], 1'b1);
    step(4);
    chk("zd_b2b_done_N9", d_done[1], 1'b1);
    chk("zd_b2b_active_N9", d_act[1], 1'b0);

    // reset during SETTLE
    v_in[0] = 1'b1; s_in[0] = 1'b1;
    step(1);
    v_in[0] = 1'b0;
    step(7);
    chk("mid_select_N7", d_sel[0], 1'b1);
    chk("mid_busy_N7", d_busy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_select", d_sel[0], 1'b0);
    chk("mid_rst_busy", d_busy[0], 1'b0);
    chk("mid_rst_ready", d_ready[0], 1'b0);
    chk("mid_rst_done", d_done[0], 1'b0);
    step(12);
    chk("mid_rst_no_done", d_done[0], 1'b0);
    rst = 1'b0;
    step(1);
    chk("post_rst_ready", d_ready[0], 1'b1);
    v_in[0] = 1'b1; s_in[0] = 1'b1;
    step(1);
    v_in[0] = 1'b0;
    chk("post_select_M", d_sel[0], 1'b1);
    step(15);
    chk("post_done_M15", d_done[0], 1'b0);
    step(1);
    chk("post_done_M16", d_done[0], 1'b1);
    chk("post_active_M16", d_act[0], 1'b1);
    step(31);
    chk("post_ready_M47", d_ready[0], 1'b0);
    step(1);
    chk("post_ready_M48", d_ready[0], 1'b1);
    chk("post_busy_M48", d_busy[0], 1'b0);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_switch_controller.md
# clock_switch_controller

Single-clock sequencer that owns the `select` input of the glitch-free clock multiplexer. It accepts clock-source change requests over a valid/ready handshake, drives `select`, waits a programmable settle time covering the multiplexer's synchronizer stages in both source domains, and then signals completion. It also enforces a minimum dwell time before the next switch is accepted, so downstream logic sees only clean, rate-limited source changes.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 16: cycles from a `select` toggle until the switch is reported complete.
  - Must be ≥ 1.
  - Must cover 2×STAGES periods of the slower multiplexed clock, expressed in `clock` cycles.
- `DWELL_CYCLES`, default 32: minimum cycles after completion before a new request is accepted. 0 is allowed.
- `RESET_SELECT`, default 0: value of `select` and `active_select` during and after reset.

Ports:
- `clock`  in  1  controller clock. Always-on; independent of both multiplexed clocks.
- `reset`  in  1  asynchronous, active-high reset.
- `request_valid`  in  1  a switch request is presented.
- `request_select`  in  1  requested source: 0 selects `clock_0`, 1 selects `clock_1`.
- `request_ready`  out  1  the controller can accept a request.
- `select`  out  1  registered; drives the multiplexer's `select`.
- `active_select`  out  1  the source confirmed as settled on the multiplexer output.
- `busy`  out  1  high in SETTLE and DWELL.
- `done`  out  1  one-cycle pulse when a request completes.

## Operation

- FSM states: IDLE, SETTLE, DWELL. There is one shared cycle counter, width $clog2(max(SETTLE_CYCLES, DWELL_CYCLES)+1).
- All outputs are registered. Reset values:
  - `select` = `active_select` = RESET_SELECT.
  - `request_ready` = 0, `busy` = 0, `done` = 0.
  - State = IDLE, counter = 0.
- `request_ready` is the registered value of (next state == IDLE). It rises on the first edge after `reset` deasserts.
- A handshake occurs at a rising edge where `request_valid` && `request_ready`.
- Handshake in IDLE with `request_select` == `select` (no-op request):
  - `done` pulses.
  - State stays IDLE and `request_ready` stays 1.
  - No dwell is applied.
- Handshake in IDLE with `request_select` != `select`:
  - `select` <= `request_select`.
  - State <= SETTLE, counter <= 0.
  - `request_ready` <= 0, `busy` <= 1.
- SETTLE:
  - The counter increments every cycle.
  - At the edge where the counter == SETTLE_CYCLES−1:
    - `done` <= 1 for one cycle.
    - `active_select` <= `select`.
    - Counter <= 0.
    - State <= DWELL, or <= IDLE when DWELL_CYCLES == 0.
- DWELL:
  - The counter increments every cycle.
  - At the edge where the counter == DWELL_CYCLES−1: state <= IDLE, `request_ready` <= 1, `busy` <= 0.
- `request_valid` held while `request_ready` is low: the request is stalled, not dropped or errored.
  - `request_select` must stay stable while stalled.
  - The request is accepted on the first edge with `request_ready` high.
- `select` never changes except on an accepted toggle or on reset.
- Reset asserted mid-operation, in any state:
  - All outputs return to their reset values immediately (asynchronously).
  - The in-flight request is lost and no `done` is generated.
  - `select` may jump to RESET_SELECT. The downstream multiplexer absorbs this glitch-free.

## Timing

- Accepted toggle at edge N:
  - `select` changes at edge N.
  - `done` is high from edge N+SETTLE_CYCLES to edge N+SETTLE_CYCLES+1.
  - `active_select` updates at edge N+SETTLE_CYCLES.
  - `request_ready` returns high at edge N+SETTLE_CYCLES+DWELL_CYCLES.
- The earliest next handshake is at edge N+SETTLE_CYCLES+DWELL_CYCLES+1.
- No-op request at edge N: `done` is high for the cycle after edge N. The next handshake is possible at edge N+1.
- `busy` goes high at edge N and low at edge N+SETTLE_CYCLES+DWELL_CYCLES, aligned with `request_ready`.
- Throughput: at most one `select` toggle per SETTLE_CYCLES+DWELL_CYCLES+1 cycles.
- No combinational path from inputs to outputs.

## Test plan

1. **Reset values.** Assert `reset` with RESET_SELECT=0, then release it.
   - During reset: `select`=0, `active_select`=0, `request_ready`=0, `busy`=0, `done`=0.
   - `request_ready`=1 one edge after release.
2. **Single toggle.** Defaults (16/32). Request `request_select`=1 accepted at edge N.
   - `select`=1 at N.
   - `done` high for exactly one cycle at N+16; `active_select`=1 at N+16.
   - `request_ready`=1 at N+48.
3. **No-op request.** With `select`=0, request `request_select`=0.
   - `done` pulses one cycle after the handshake.
   - `select` unchanged; `busy` stays 0; `request_ready` never drops.
4. **Stalled request.** Hold `request_valid` with `request_select`=0 from N+5 after the toggle in scenario 2.
   - The request is accepted at edge N+49.
   - `select`=0 at N+49; `done` at N+65.
5. **Zero dwell.** DWELL_CYCLES=0, SETTLE_CYCLES=4. Toggle at edge N.
   - `done` and `request_ready` both rise at N+4.
   - A back-to-back request is accepted at N+5.
6. **Reset mid-operation.** Assert `reset` at N+7 during SETTLE, with `select`=1 and RESET_SELECT=0.
   - `select`, `busy` and `request_ready` drop immediately.
   - No `done` pulse.
   - After release, a new toggle to 1 completes with full SETTLE and DWELL timing.
